press_decoder: RTL

//  Sits downstream of the 8-sample input debounce filter and takes its clean level.

---
 rtl/press_decoder_if.sv | 13 +
 rtl/press_decoder.sv | 103 ++++++++++
 2 files changed

// File: rtl/press_decoder_if.sv
// Button-level bundle between the debounce side (master) and the press decoder (slave).
// A level goes in and registered event pulses come out. There is no backpressure and no valid/ready pair.
interface press_decoder_if;
  logic       d;
  logic       short_p;
  logic       long_p;
  logic       double_p;
  logic       held;
  logic [7:0] press_cnt;

  modport master (output d, input short_p, long_p, double_p, held, press_cnt);
  modport slave  (input d, output short_p, long_p, double_p, held, press_cnt);
endinterface

// File: rtl/press_decoder.sv
// Turns a debounced button level into short/long/double-click pulses.
// Also produces a held level and a wrapping press counter. state_dbg mirrors the FSM state.
module press_decoder #(
  parameter int LONG_CYCLES = 16,
  parameter int DBL_GAP     = 8,
  parameter int TW          = 8
) (
  input  logic              clk,
  input  logic              rst,
  press_decoder_if.slave    bus,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {IDLE, PRESS1, LONG, GAP, PRESS2} state_t;

  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(DBL_GAP - 1);
  localparam logic [TW-1:0] TICK      = TW'(1);

  state_t        state;
  logic [TW-1:0] timer;
  logic          d_q;
  logic          rise;
  logic          fall;

  assign rise      = bus.d & ~d_q;
  assign fall      = ~bus.d & d_q;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      d_q           <= 1'b0;
      bus.short_p   <= 1'b0;
      bus.long_p    <= 1'b0;
      bus.double_p  <= 1'b0;
      bus.held      <= 1'b0;
      bus.press_cnt <= 8'd0;
    end else begin
      d_q          <= bus.d;
      bus.short_p  <= 1'b0;
      bus.long_p   <= 1'b0;
      bus.double_p <= 1'b0;
      if (rise) bus.press_cnt <= bus.press_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS1;
            timer <= '0;
          end
        end
        PRESS1: begin
          // A release in the timeout cycle still counts as a short candidate.
          if (fall) begin
            state <= GAP;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state      <= LONG;
            timer      <= '0;
            bus.long_p <= 1'b1;
            bus.held   <= 1'b1;
          end else begin
            timer <= timer + TICK;
          end
        end
        LONG: begin
          if (fall) begin
            state    <= IDLE;
            timer    <= '0;
            bus.held <= 1'b0;
          end
        end
        GAP: begin
          // A second press in the timeout cycle still makes a double click.
          if (rise) begin
            state        <= PRESS2;
            timer        <= '0;
            bus.double_p <= 1'b1;
          end else if (timer == GAP_LAST) begin
            state       <= IDLE;
            timer       <= '0;
            bus.short_p <= 1'b1;
          end else begin
            timer <= timer + TICK;
          end
        end
        PRESS2: begin
          if (fall) begin
            state <= IDLE;
            timer <= '0;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
